// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM state type
// and the funct3 legality helpers used by the fault decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {LSU_IDLE, LSU_RMW_WR} lsu_state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory word,
// and merges store data into a memory word for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, lane_b};
            F3_HU:   load_data = {16'd0, lane_h};
            default: load_data = 32'd0;
        endcase

        // Untouched lanes keep the value just read from memory.
        merged = word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) merged[31:16] = store_data[15:0];
                else           merged[15:0]  = store_data[15:0];
            end
            F3_W:    merged = store_data;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage adapter onto a word-only data memory: sub-word loads by lane extraction,
// sub-word stores by a stalled read-modify-write, and suppression of faulting accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    output logic        mem_MemRW,
    input  logic [31:0] mem_dataR,
    output lsu_state_t  lsu_state
);

    // Memory size is informational only; no range checks are made here.
    logic unused_depth;
    assign unused_depth = ^DEPTH_WORDS;

    lsu_state_t  state_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;

    logic [31:0] aligned_addr;
    logic [31:0] extracted;
    logic [31:0] merged;
    logic        idle;
    logic        req;
    logic        bad_access;
    logic        load_ok;
    logic        store_ok;
    logic        word_store;
    logic        sub_store;

    lsu_lane_align u_lane_align (
        .word       (mem_dataR),
        .offset     (addr[1:0]),
        .funct3     (funct3),
        .store_data (store_data),
        .load_data  (extracted),
        .merged     (merged)
    );

    always_comb begin
        aligned_addr = {addr[31:2], 2'b00};
        idle         = !rst && (state_q == LSU_IDLE);
        req          = is_load || is_store;
        bad_access   = (is_load && is_store)
                    || (is_load && !load_f3_ok(funct3))
                    || (is_store && !store_f3_ok(funct3))
                    || ((funct3 == F3_W) && (addr[1:0] != 2'b00))
                    || (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]);
        load_ok      = idle && is_load && !bad_access;
        store_ok     = idle && is_store && !bad_access;
        word_store   = store_ok && (funct3 == F3_W);
        sub_store    = store_ok && (funct3 != F3_W);
    end

    // Memory port mux; in RMW_WR the registered write wins regardless of inputs.
    always_comb begin
        mem_addr  = addr;
        mem_dataW = store_data;
        mem_MemRW = 1'b0;
        if (state_q == LSU_RMW_WR) begin
            mem_addr  = wr_addr_q;
            mem_dataW = wr_data_q;
            mem_MemRW = !rst;
        end else begin
            if (req) mem_addr = aligned_addr;
            if (word_store) mem_MemRW = 1'b1;
        end
        stall     = sub_store;
        fault     = idle && req && bad_access;
        load_data = load_ok ? extracted : 32'd0;
        lsu_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            wr_addr_q <= 32'd0;
            wr_data_q <= 32'd0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (sub_store) begin
                        state_q   <= LSU_RMW_WR;
                        wr_addr_q <= aligned_addr;
                        wr_data_q <= merged;
                    end
                end
                LSU_RMW_WR: state_q <= LSU_IDLE;
                default:    state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory with switch/LED registers, a reference model
// of memory contents and load/fault rules, and an expected-write scoreboard.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam logic [31:0] SW_ADDR  = 32'h0001_0000;
    localparam logic [31:0] LED_ADDR = 32'h0001_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic        mem_MemRW;
    logic [31:0] mem_dataR;
    lsu_state_t  lsu_state;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] switches;
    logic [31:0] led;
    logic        mem_init;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mon_a;
    logic [31:0] mon_d;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .fault      (fault),
        .mem_addr   (mem_addr),
        .mem_dataW  (mem_dataW),
        .mem_MemRW  (mem_MemRW),
        .mem_dataR  (mem_dataR),
        .lsu_state  (lsu_state)
    );

    // Data memory: combinational read, write on the clock edge; LED reads back as 0.
    always_comb begin
        if (mem_addr == SW_ADDR)           mem_dataR = switches;
        else if (mem_addr[31:12] == 20'd0) mem_dataR = mem[mem_addr[11:2]];
        else                               mem_dataR = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
            led <= 32'd0;
        end else if (mem_MemRW === 1'b1) begin
            if (mem_addr == LED_ADDR)          led <= mem_dataW;
            else if (mem_addr[31:12] == 20'd0) mem[mem_addr[11:2]] <= mem_dataW;
        end
    end

    // Every memory write must match the next expected write, in order.
    always @(negedge clk) begin
        if (mem_MemRW === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_dataW);
            end else begin
                mon_a = exp_addr_q.pop_front();
                mon_d = exp_q.pop_front();
                if (mem_addr !== mon_a || mem_dataW !== mon_d) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             mem_addr, mem_dataW, mon_a, mon_d);
                end
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        int unsigned sh;
        v = 32'd0;
        if (f3 == F3_B || f3 == F3_BU) begin
            sh = 8 * int'(a[1:0]);
            v  = (word >> sh) & 32'hFF;
            if (f3 == F3_B && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == F3_H || f3 == F3_HU) begin
            sh = 16 * int'(a[1]);
            v  = (word >> sh) & 32'hFFFF;
            if (f3 == F3_H && v >= 32'd32768) v = v - 32'd65536;
        end else if (f3 == F3_W) begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] a,
                                              input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] mask;
        int unsigned sh;
        if (f3 == F3_B) begin
            mask = 32'hFF;
            sh   = 8 * int'(a[1:0]);
        end else if (f3 == F3_H) begin
            mask = 32'hFFFF;
            sh   = 16 * int'(a[1]);
        end else begin
            mask = 32'hFFFF_FFFF;
            sh   = 0;
        end
        return (word & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic logic ref_fault(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (ld && (f3 inside {3'b011, 3'b110, 3'b111})) return 1'b1;
        if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b1;
        if (f3 == F3_W && a[1:0] != 2'b00) return 1'b1;
        if ((f3 == F3_H || f3 == F3_HU) && a[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    endtask

    // Pipeline-style issue: the request is held in MEM while stall is high.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, output int ncyc,
                         output logic first_stall, output logic first_rw,
                         output logic [31:0] ld_out, output logic flt);
        ncyc = 0;
        first_stall = 1'b0; first_rw = 1'b0; ld_out = 32'd0; flt = 1'b0;
        do begin
            @(posedge clk); #1;
            is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
            @(negedge clk);
            if (ncyc == 0) begin
                first_stall = stall; first_rw = mem_MemRW; ld_out = load_data; flt = fault;
            end
            ncyc++;
        end while (stall === 1'b1 && ncyc < 8);
        if (ncyc >= 8) begin
            n_vec++; n_err++;
            $display("FAIL stall_timeout got=%0d cycles exp=<8", ncyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1; switches = 32'd0;
        is_load = 1'b1; is_store = 1'b1; funct3 = F3_B; addr = 32'h41; store_data = 32'h12;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_vec++; if (mem_MemRW !== 1'b0) begin n_err++; $display("FAIL reset_rw got=%b exp=0", mem_MemRW); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
        n_vec++; if (load_data !== 32'd0) begin n_err++; $display("FAIL reset_ld got=%h exp=0", load_data); end
        n_vec++; if (lsu_state !== LSU_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=0", lsu_state); end
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endtask

    task automatic test_loads();
        int nc; logic fs, fr, fl; logic [31:0] ld;
        logic [31:0] a_tab [4];
        logic [2:0]  f_tab [4];
        logic [31:0] e_tab [4];
        a_tab = '{32'h43, 32'h43, 32'h42, 32'h40};
        f_tab = '{F3_B, F3_BU, F3_H, F3_HU};
        e_tab = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};
        push_wr(32'h40, 32'h8899_AABB);
        ref_mem[16] = 32'h8899_AABB;
        issue(1'b0, 1'b1, F3_W, 32'h40, 32'h8899_AABB, nc, fs, fr, ld, fl);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, f_tab[i], a_tab[i], 32'd0, nc, fs, fr, ld, fl);
            n_vec++;
            if (ld !== e_tab[i] || fs !== 1'b0) begin
                n_err++;
                $display("FAIL load_%0d got=%h stall=%b exp=%h stall=0", i, ld, fs, e_tab[i]);
            end
        end
    endtask

    task automatic test_sub_store();
        int nc; logic fs, fr, fl; logic [31:0] ld;
        push_wr(32'h40, 32'h8899_12BB);
        ref_mem[16] = 32'h8899_12BB;
        issue(1'b0, 1'b1, F3_B, 32'h41, 32'h0000_0012, nc, fs, fr, ld, fl);
        n_vec++; if (fs !== 1'b1 || fr !== 1'b0) begin n_err++; $display("FAIL sb_cycle0 got stall=%b rw=%b exp stall=1 rw=0", fs, fr); end
        n_vec++; if (nc != 2) begin n_err++; $display("FAIL sb_cycles got=%0d exp=2", nc); end
        issue(1'b1, 1'b0, F3_W, 32'h40, 32'd0, nc, fs, fr, ld, fl);
        n_vec++; if (ld !== 32'h8899_12BB) begin n_err++; $display("FAIL lw_after_sb got=%h exp=889912bb", ld); end
    endtask

    task automatic test_back_to_back();
        int nc0, nc1, nc2; logic fs, fr, fl; logic [31:0] ld;
        push_wr(32'h40, 32'h8899_AABB);
        issue(1'b0, 1'b1, F3_W, 32'h40, 32'h8899_AABB, nc0, fs, fr, ld, fl);
        push_wr(32'h40, 32'hCAFE_AABB);
        push_wr(32'h40, 32'hCAFE_AA55);
        ref_mem[16] = 32'hCAFE_AA55;
        issue(1'b0, 1'b1, F3_H, 32'h42, 32'h0000_CAFE, nc1, fs, fr, ld, fl);
        issue(1'b0, 1'b1, F3_B, 32'h40, 32'h0000_0055, nc2, fs, fr, ld, fl);
        drive_idle();
        n_vec++; if (nc1 + nc2 != 4) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=4", nc1 + nc2); end
        n_vec++; if (mem[16] !== 32'hCAFE_AA55) begin n_err++; $display("FAIL b2b_word got=%h exp=cafeaa55", mem[16]); end
    endtask

    task automatic test_faults();
        int nc; logic fs, fr, fl; logic [31:0] ld;
        logic        l_tab [5];
        logic        s_tab [5];
        logic [2:0]  f_tab [5];
        logic [31:0] a_tab [5];
        l_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        s_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        f_tab = '{F3_W, F3_H, 3'b011, F3_W, F3_BU};
        a_tab = '{32'h42, 32'h45, 32'h40, 32'h40, 32'h40};
        for (int i = 0; i < 5; i++) begin
            issue(l_tab[i], s_tab[i], f_tab[i], a_tab[i], 32'hDEAD_BEEF, nc, fs, fr, ld, fl);
            n_vec++;
            if (fl !== 1'b1 || ld !== 32'd0 || fs !== 1'b0 || fr !== 1'b0 || nc != 1) begin
                n_err++;
                $display("FAIL fault_%0d got fault=%b ld=%h stall=%b rw=%b exp fault=1 ld=0 stall=0 rw=0",
                         i, fl, ld, fs, fr);
            end
        end
        drive_idle();
        n_vec++; if (lsu_state !== LSU_IDLE) begin n_err++; $display("FAIL fault_state got=%0d exp=0", lsu_state); end
        n_vec++; if (mem[16] !== ref_mem[16] || mem[17] !== ref_mem[17]) begin
            n_err++; $display("FAIL fault_mem got=%h %h exp=%h %h", mem[16], mem[17], ref_mem[16], ref_mem[17]);
        end
    endtask

    task automatic test_reset_rmw();
        @(posedge clk); #1;
        is_load = 1'b0; is_store = 1'b1; funct3 = F3_B; addr = 32'h40; store_data = 32'h77;
        @(negedge clk);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_rmw_cycle0 got=%b exp=1", stall); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_MemRW !== 1'b0) begin n_err++; $display("FAIL rst_rmw_rw got=%b exp=0", mem_MemRW); end
        @(posedge clk); #1;
        rst = 1'b0;
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        @(negedge clk);
        n_vec++; if (lsu_state !== LSU_IDLE) begin n_err++; $display("FAIL rst_rmw_state got=%0d exp=0", lsu_state); end
        n_vec++; if (mem[16] !== ref_mem[16]) begin n_err++; $display("FAIL rst_rmw_mem got=%h exp=%h", mem[16], ref_mem[16]); end
    endtask

    task automatic test_mmio();
        int nc; logic fs, fr, fl; logic [31:0] ld;
        switches = 32'h0000_00A5;
        issue(1'b1, 1'b0, F3_W, SW_ADDR, 32'd0, nc, fs, fr, ld, fl);
        n_vec++; if (ld !== 32'h0000_00A5) begin n_err++; $display("FAIL mmio_switch got=%h exp=000000a5", ld); end
        push_wr(LED_ADDR, 32'h0000_003C);
        issue(1'b0, 1'b1, F3_W, LED_ADDR, 32'h0000_003C, nc, fs, fr, ld, fl);
        drive_idle();
        n_vec++; if (led !== 32'h0000_003C || nc != 1) begin n_err++; $display("FAIL mmio_led got=%h cycles=%0d exp=3c cycles=1", led, nc); end
        push_wr(LED_ADDR, 32'h0000_5A00);
        issue(1'b0, 1'b1, F3_B, LED_ADDR + 32'd1, 32'h0000_005A, nc, fs, fr, ld, fl);
        drive_idle();
        n_vec++; if (led !== 32'h0000_5A00) begin n_err++; $display("FAIL mmio_led_sb got=%h exp=00005a00", led); end
    endtask

    task automatic test_random();
        int nc, e_nc; logic fs, fr, fl; logic [31:0] ld;
        logic l, s, e_flt, e_sub, e_sw;
        logic [2:0] f3;
        logic [31:0] a, d, e_ld, nw;
        int sel;
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f3 = '{F3_B, F3_H, F3_W};
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 19));
            l = (sel < 9) || (sel == 19);
            s = (sel >= 9 && sel < 18) || (sel == 19);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (s && !l)              f3 = st_f3[$urandom_range(0, 2)];
            else                           f3 = ld_f3[$urandom_range(0, 4)];
            a = {20'd0, 12'($urandom_range(0, 4095))};
            if ($urandom_range(0, 4) != 0) begin
                if (f3 == F3_W) a[1:0] = 2'b00;
                else if (f3 == F3_H || f3 == F3_HU) a[0] = 1'b0;
            end
            d = $urandom;
            e_flt = ref_fault(l, s, f3, a);
            e_ld  = (l && !e_flt) ? ref_load(ref_mem[a[11:2]], a, f3) : 32'd0;
            e_sub = s && !e_flt && (f3 != F3_W);
            e_sw  = s && !e_flt && (f3 == F3_W);
            e_nc  = e_sub ? 2 : 1;
            if (s && !e_flt) begin
                nw = ref_merge(ref_mem[a[11:2]], a, f3, d);
                ref_mem[a[11:2]] = nw;
                push_wr({a[31:2], 2'b00}, nw);
            end
            issue(l, s, f3, a, d, nc, fs, fr, ld, fl);
            n_vec++;
            if (ld !== e_ld || fl !== e_flt || fs !== e_sub || fr !== e_sw || nc != e_nc) begin
                n_err++;
                $display("FAIL rand_%0d ld=%b st=%b f3=%0d a=%h got ld=%h f=%b st=%b rw=%b n=%0d exp ld=%h f=%b st=%b rw=%b n=%0d",
                         k, l, s, f3, a, ld, fl, fs, fr, nc, e_ld, e_flt, e_sub, e_sw, e_nc);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_store();
        test_back_to_back();
        test_faults();
        test_reset_rmw();
        test_mmio();
        test_random();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_writes got=%0d exp=0", exp_q.size());
        end
        for (int i = 0; i < 1024; i++) begin
            n_vec++;
            if (mem[i] !== ref_mem[i]) begin
                n_err++;
                $display("FAIL final_mem[%0d] got=%h exp=%h", i, mem[i], ref_mem[i]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
